// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the column-serial MixColumns stage: input state channel,
// output state channel and the busy status flag.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns, one 32-bit column per clock over a
// valid/ready input channel and a registered valid/ready output channel.
module mix_columns_seq #(
    parameter logic [8:0] MOD_POL = 9'h11B
) (
    input  logic          clk,
    input  logic          rst,
    mix_columns_seq_if.slave mc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_reg;
    logic [1:0]   col_reg;
    logic [127:0] work_reg;
    logic         mode_reg;
    logic         out_valid_reg;
    logic         busy_reg;

    logic [31:0]  col_word;
    logic [31:0]  col_out;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ ({8{v[7]}} & MOD_POL[7:0]);
    endfunction

    // Column 0 sits in the top 32 bits, so the column index counts downward in bit position.
    assign col_word = work_reg[127 - 32*int'(col_reg) -: 32];

    logic [7:0] a   [4];
    logic [7:0] m2  [4];
    logic [7:0] m4  [4];
    logic [7:0] m8  [4];
    logic [7:0] m3  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mult
            assign a[gi]   = col_word[31-8*gi -: 8];
            assign m2[gi]  = xtime(a[gi]);
            assign m4[gi]  = xtime(m2[gi]);
            assign m8[gi]  = xtime(m4[gi]);
            assign m3[gi]  = m2[gi] ^ a[gi];
            assign m9[gi]  = m8[gi] ^ a[gi];
            assign m11[gi] = m8[gi] ^ m2[gi] ^ a[gi];
            assign m13[gi] = m8[gi] ^ m4[gi] ^ a[gi];
            assign m14[gi] = m8[gi] ^ m4[gi] ^ m2[gi];
        end

        // Each output row uses the same coefficient set rotated by its row index.
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            logic [7:0] fwd_b;
            logic [7:0] inv_b;
            assign fwd_b = m2[gi] ^ m3[(gi+1)%4] ^ a[(gi+2)%4] ^ a[(gi+3)%4];
            assign inv_b = m14[gi] ^ m11[(gi+1)%4] ^ m13[(gi+2)%4] ^ m9[(gi+3)%4];
            assign col_out[31-8*gi -: 8] = mode_reg ? inv_b : fwd_b;
        end
    endgenerate

    assign mc.in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && mc.out_ready);
    assign accept       = mc.in_valid && mc.in_ready;
    assign mc.out_valid = out_valid_reg;
    assign mc.out_data  = work_reg;
    assign mc.busy      = busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            col_reg       <= 2'd0;
            work_reg      <= 128'd0;
            mode_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        work_reg  <= mc.in_data;
                        mode_reg  <= mc.in_inv;
                        col_reg   <= 2'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    work_reg[127 - 32*int'(col_reg) -: 32] <= col_out;
                    col_reg <= col_reg + 2'd1;
                    if (col_reg == 2'd3) begin
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (mc.out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (mc.in_valid) begin
                            work_reg  <= mc.in_data;
                            mode_reg  <= mc.in_inv;
                            col_reg   <= 2'd0;
                            busy_reg  <= 1'b1;
                            state_reg <= BUSY;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Column-serial AES MixColumns / InvMixColumns stage. It sits directly downstream of the ShiftRows output and consumes GF(2^8) products. Products are formed with the reduction polynomial x^8+x^4+x^3+x+1 (0x11B), using the team's combinational GF(2^8) multiplier or equivalent xtime logic. The block accepts a 128-bit state over a valid/ready handshake, transforms one 32-bit column per clock, and presents the result over a second valid/ready handshake.

Parameters:
MOD_POL, 9'h11B, field reduction polynomial; fixed for AES and must not be overridden.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents in_data/in_inv
in_ready  output  1  block can accept a state this cycle
in_data  input  128  state; byte s0 = [127:120] ... s15 = [7:0]; column c = bytes s(4c)..s(4c+3), s(4c) is row 0
in_inv  input  1  0 = MixColumns, 1 = InvMixColumns
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts out_data
out_data  output  128  transformed state, same byte ordering as in_data
busy  output  1  high while a column computation is in progress

Behaviour:
- Reset is one clock; rst is asynchronous and active-high, with no synchronous clear path.
- On reset: state = IDLE, col counter = 0, out_valid = 0, out_data = 0, busy = 0, internal state/mode registers = 0. in_ready reads 1 immediately after reset release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready: latch in_data into the working register, latch in_inv into mode, set col = 0, go to BUSY.
- BUSY:
  - in_ready = 0, busy = 1.
  - Each cycle, replace column col in the working register with its transform; col increments 0..3.
  - After col = 3 is written, go to DONE and set out_valid = 1.
  - Column order is fixed 0,1,2,3.
- Forward transform, per column a0..a3 (rows 0..3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse transform: same structure with coefficients {0E,0B,0D,09} rotated per row. Row 0 = 0E a0 ^ 0B a1 ^ 0D a2 ^ 09 a3.
- All arithmetic is GF(2^8): XOR addition, multiplication reduced modulo MOD_POL, and every result is exactly 8 bits.
- DONE:
  - out_valid = 1; out_data = working register. out_data is driven from a register, not combinationally from the datapath.
  - out_data and out_valid hold stable while out_ready = 0, with no limit on stall length.
  - out_valid & out_ready: result is transferred.
    - If in_valid is also high the same cycle, in_ready = 1 (in_ready = out_ready in DONE). The new state is accepted, out_valid drops, next state is BUSY. Back-to-back throughput is one state per 5 cycles.
    - Otherwise go to IDLE with out_valid = 0.
- Latency: acceptance at edge k → out_valid high after edge k+4 (4 cycles).
- Mode is sampled only at acceptance; changes to in_inv while BUSY/DONE are ignored. Changes to in_data after acceptance are ignored.
- in_valid while BUSY is not accepted and not lost. Upstream must hold it; the block accepts it when in_ready next rises.
- Reset asserted mid-operation (BUSY or DONE): the partial/held result is discarded, outputs take reset values asynchronously, and no output handshake occurs.
- in_ready is combinational from state and out_ready only. There is no path from in_valid to in_ready.

Test Plan:
- Forward, FIPS-197 columns: in_data = db135345_f20a225c_01010101_c6c6c6c6, in_inv = 0 → out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 4 cycles after acceptance; busy high for those 4 cycles.
- Inverse round trip: in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv = 1 → out_data = db135345_f20a225c_01010101_c6c6c6c6. Also: forward d4d4d4d5_2d26314c_00000000_ffffffff → d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_data/out_valid unchanged, in_ready = 0. Raise out_ready → one transfer, then IDLE, in_ready = 1.
- Back-to-back: second in_valid presented in the same cycle as the out_valid & out_ready transfer → accepted that cycle. Second result appears 4 cycles later with correct mode, even when in_inv differs between the two states.
- Input while BUSY and mode stability: assert in_valid with different data and toggle in_inv during BUSY → first result unaffected; the second state is accepted only after the first transfer.
- Reset mid-BUSY (col = 2): assert rst asynchronously → out_valid = 0, out_data = 0, busy = 0, in_ready = 1 after release. A fresh state then completes correctly.
